bp_table_ctrl: RTL and testbench
================================

# bp_table_ctrl

Controller for the branch-prediction pattern table built from 2-bit saturating counters. It owns a 2^IDX_W-entry counter array and the global history register (GHR). It arbitrates the single table access slot per cycle between fetch-stage lookups and a queue of execute-stage resolved-branch updates. It also runs the post-reset table initialisation sweep. It sits between the fetch stage (prediction request) and the execute stage (branch resolution).

## Interface
- IDX_W, 6, table index width; table has 2^IDX_W entries; GHR is also IDX_W bits
- QDEPTH, 4, update queue depth (power of two, >= 2)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- i_lookup_valid  in  1  fetch requests a prediction
- i_lookup_pc  in  32  PC of fetched instruction
- o_lookup_ready  out  1  lookup accepted this cycle when high with i_lookup_valid
- o_pred_valid  out  1  prediction result valid
- o_pred_taken  out  1  predicted direction (counter MSB)
- o_pred_idx  out  IDX_W  table index used; returned by execute with the update
- i_upd_valid  in  1  resolved branch update offered
- i_upd_idx  in  IDX_W  index from o_pred_idx of that branch
- i_upd_taken  in  1  actual outcome
- o_upd_ready  out  1  update accepted when high with i_upd_valid
- o_init_busy  out  1  init sweep in progress

## Operation
- Counter encoding: 00 SNT, 01 WNT, 10 WTK, 11 STK. Update taken -> +1, saturating at 11. Update not-taken -> -1, saturating at 00.
- Index = i_lookup_pc[IDX_W+1:2] XOR ghr.
- Top FSM has two states:
  - INIT: on reset. A sweep pointer 0..2^IDX_W-1 writes 00 to one entry per cycle. After writing the last entry, go to RUN.
  - RUN: normal operation. INIT is never re-entered except by rst.
- Update queue: FIFO of {idx, taken}.
  - Enqueue when i_upd_valid && o_upd_ready.
  - On enqueue, ghr <= {ghr[IDX_W-2:0], i_upd_taken}.
- Slot arbitration in RUN, one table access per cycle:
  - Queue full: drain has priority, o_lookup_ready = 0.
  - Otherwise, a lookup present takes the slot and the queue holds.
  - Otherwise, if the queue is non-empty, drain the head: read-modify-write of that entry in the same cycle.
- o_lookup_ready = RUN && !full.
- o_upd_ready = RUN && !full. It is computed from registered state only. Enqueue and dequeue in the same cycle are legal and leave the count unchanged.
- Lookups read the table before any queued, undrained updates are applied (stale reads allowed). There is no forwarding from the queue.
- Lookup in the same cycle as an enqueue uses the pre-shift GHR.

## Timing
- Reset values:
  - o_pred_valid = 0, o_pred_taken = 0, o_pred_idx = 0
  - o_init_busy = 1, o_lookup_ready = 0, o_upd_ready = 0
  - ghr = 0, queue empty, sweep pointer = 0
- Init takes exactly 2^IDX_W cycles after rst deasserts. o_init_busy falls on the edge that writes the last entry (64 cycles for IDX_W=6).
- Lookup latency is 1 cycle. A lookup accepted at edge N gives o_pred_valid/o_pred_taken/o_pred_idx valid after edge N+1, held for one cycle. o_pred_valid is 0 in any cycle with no accepted lookup.
- Queued update latency is at least 1 cycle: the earliest drain is the cycle after enqueue. The counter is visible to a lookup accepted after the drain edge.
- Back-to-back lookups are sustained at 1 per cycle while the queue is not full.
- rst mid-operation:
  - Queue is flushed, ghr cleared, any in-flight prediction dropped (o_pred_valid = 0).
  - FSM re-enters INIT and the full sweep repeats.

## Configuration
- BP_STATS_EN defined adds two outputs:
  - o_stat_lookups [15:0]: +1 per accepted lookup, wraps at 16'hFFFF -> 0.
  - o_stat_updates [15:0]: +1 per drained update, wraps at 16'hFFFF -> 0.
  - Both reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset then idle: o_init_busy high for 64 cycles (IDX_W=6), then 0. Ready signals rise with it. A lookup at PC 0x100 then returns o_pred_taken = 0, o_pred_idx = 0x00.
- Training: three updates taken on idx 5 with ghr start 0, drained. A lookup mapping to idx 5 predicts taken; the first taken update alone gives WNT and predicts not-taken.
- Saturation: five taken updates on idx 3 leave the counter at 11. One not-taken gives 10 and still predicts taken. Five not-taken give 00 with no wrap.
- Full-queue priority: continuous lookups with four updates enqueued. Queue full -> o_lookup_ready = 0 for the drain cycle, and lookups resume the next cycle. No update is lost; the counters match the reference model.
- GHR indexing: enqueue outcomes 1,0,1 -> ghr = 6'b000101. A lookup at PC 0x0 uses idx 0x05.
- Reset mid-RUN with two queued updates: the queue is discarded, o_pred_valid = 0, and a full 64-cycle init repeats. The previously trained entries read 00.

Source files
------------

// File: rtl/bp_table_ctrl.sv
// ============================================================================
// Module      : bp_table_ctrl
// Description : 2-bit saturating-counter branch pattern table with GHR, update
//               queue and post-reset init sweep. Optional statistics counters
//               are enabled by defining BP_STATS_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bp_table_ctrl #(
  parameter int IDX_W  = 6,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_lookup_valid,
  input  logic [31:0]      i_lookup_pc,
  output logic             o_lookup_ready,
  output logic             o_pred_valid,
  output logic             o_pred_taken,
  output logic [IDX_W-1:0] o_pred_idx,
  input  logic             i_upd_valid,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken,
  output logic             o_upd_ready,
`ifdef BP_STATS_EN
  output logic [15:0]      o_stat_lookups,
  output logic [15:0]      o_stat_updates,
`endif
  output logic             o_init_busy
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int QW      = $clog2(QDEPTH);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state, state_nxt;
  logic             run;
  logic [IDX_W-1:0] sweep_ptr;
  logic [IDX_W-1:0] ghr;
  logic [1:0]       ctr_tbl [ENTRIES];

  logic [IDX_W-1:0] q_idx [QDEPTH];
  logic [QDEPTH-1:0] q_taken;
  logic [QW:0]      wr_ptr, rd_ptr;
  logic             q_full, q_empty;

  logic             lookup_acc, enq, deq;
  logic [IDX_W-1:0] lookup_idx, head_idx;
  logic             head_taken;
  logic [1:0]       head_ctr, head_ctr_nxt;
  logic             unused_pc;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && sweep_ptr == IDX_W'(ENTRIES - 1))
      state_nxt = ST_RUN;
  end

  always_comb begin
    run         = (state == ST_RUN);
    o_init_busy = (state == ST_INIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  sweep_ptr <= '0;
    else if (state == ST_INIT) sweep_ptr <= sweep_ptr + IDX_W'(1);
  end

  // ---------------- Queue and slot arbitration ----------------
  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[QW] != rd_ptr[QW]) && (wr_ptr[QW-1:0] == rd_ptr[QW-1:0]);

  assign o_lookup_ready = run && !q_full;
  assign o_upd_ready    = run && !q_full;

  assign lookup_idx = i_lookup_pc[IDX_W+1:2] ^ ghr;
  assign lookup_acc = i_lookup_valid && o_lookup_ready;
  assign enq        = i_upd_valid && o_upd_ready;
  // Full queue steals the slot from fetch; otherwise a lookup wins.
  assign deq        = run && !q_empty && (q_full || !i_lookup_valid);

  assign head_idx   = q_idx[rd_ptr[QW-1:0]];
  assign head_taken = q_taken[rd_ptr[QW-1:0]];
  assign head_ctr   = ctr_tbl[head_idx];
  assign unused_pc  = ^{i_lookup_pc[31:IDX_W+2], i_lookup_pc[1:0]};

  always_comb begin
    head_ctr_nxt = head_ctr;
    if (head_taken && head_ctr != 2'b11)       head_ctr_nxt = head_ctr + 2'b01;
    else if (!head_taken && head_ctr != 2'b00) head_ctr_nxt = head_ctr - 2'b01;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_idx[wr_ptr[QW-1:0]]   <= i_upd_idx;
      q_taken[wr_ptr[QW-1:0]] <= i_upd_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ghr    <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + (QW+1)'(1);
        ghr    <= {ghr[IDX_W-2:0], i_upd_taken};
      end
      if (deq) rd_ptr <= rd_ptr + (QW+1)'(1);
    end
  end

  // Table contents are established by the sweep, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (!run)     ctr_tbl[sweep_ptr] <= 2'b00;
    else if (deq) ctr_tbl[head_idx]  <= head_ctr_nxt;
  end

  // ---------------- Prediction output ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pred_valid <= 1'b0;
      o_pred_taken <= 1'b0;
      o_pred_idx   <= '0;
    end else begin
      o_pred_valid <= lookup_acc;
      if (lookup_acc) begin
        o_pred_taken <= ctr_tbl[lookup_idx][1];
        o_pred_idx   <= lookup_idx;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_stat_lookups <= 16'd0;
      o_stat_updates <= 16'd0;
    end else begin
      if (lookup_acc) o_stat_lookups <= o_stat_lookups + 16'd1;
      if (deq)        o_stat_updates <= o_stat_updates + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_table_ctrl.sv
// ============================================================================
// Module      : tb_bp_table_ctrl
// Description : Self-checking bench for bp_table_ctrl: vector table, directed
//               corner sequences and random traffic against a reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_bp_table_ctrl;

  localparam int IDX_W = 6;
  localparam int QD    = 4;
  localparam int NENT  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_lookup_valid;
  logic [31:0] i_lookup_pc;
  logic        o_lookup_ready;
  logic        o_pred_valid;
  logic        o_pred_taken;
  logic [5:0]  o_pred_idx;
  logic        i_upd_valid;
  logic [5:0]  i_upd_idx;
  logic        i_upd_taken;
  logic        o_upd_ready;
  logic        o_init_busy;
`ifdef BP_STATS_EN
  logic [15:0] o_stat_lookups;
  logic [15:0] o_stat_updates;
`endif

  bp_table_ctrl #(.IDX_W(IDX_W), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .i_lookup_valid(i_lookup_valid), .i_lookup_pc(i_lookup_pc),
    .o_lookup_ready(o_lookup_ready),
    .o_pred_valid(o_pred_valid), .o_pred_taken(o_pred_taken), .o_pred_idx(o_pred_idx),
    .i_upd_valid(i_upd_valid), .i_upd_idx(i_upd_idx), .i_upd_taken(i_upd_taken),
    .o_upd_ready(o_upd_ready),
`ifdef BP_STATS_EN
    .o_stat_lookups(o_stat_lookups), .o_stat_updates(o_stat_updates),
`endif
    .o_init_busy(o_init_busy)
  );

  always #5 clk = ~clk;

  // Reference model: counter values, pending updates, history, init countdown
  typedef struct packed { logic [5:0] idx; logic t; } upd_t;
  int   m_tbl [NENT];
  upd_t m_q [$];
  int   m_ghr;
  int   m_init;
  bit   e_pv, e_pt;
  int   e_pi;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    bit lv; logic [31:0] pc; bit uv; logic [5:0] uidx; bit ut;
    bit ev; bit et; logic [5:0] ei;
  } vec_t;
  vec_t vt [12];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(bit lv, logic [31:0] pc, bit uv, logic [5:0] uidx, bit ut);
    bit run, lacc, uacc, drn;
    int qs, idx;
    upd_t h;
    i_lookup_valid = lv; i_lookup_pc = pc;
    i_upd_valid = uv; i_upd_idx = uidx; i_upd_taken = ut;
    run = (m_init == 0);
    qs  = m_q.size();
    chk("init_busy", {31'd0, o_init_busy}, {31'd0, !run});
    chk("lookup_ready", {31'd0, o_lookup_ready}, {31'd0, run && qs < QD});
    chk("upd_ready", {31'd0, o_upd_ready}, {31'd0, run && qs < QD});
    lacc = lv && run && qs < QD;
    uacc = uv && run && qs < QD;
    drn  = run && qs > 0 && (qs == QD || !lv);
    idx  = int'((pc >> 2) & 32'h3F) ^ m_ghr;
    @(posedge clk);
    #1;
    e_pv = lacc;
    if (lacc) begin
      e_pt = (m_tbl[idx] >= 2);
      e_pi = idx;
    end
    if (drn) begin
      h = m_q.pop_front();
      if (h.t) m_tbl[h.idx] = (m_tbl[h.idx] == 3) ? 3 : m_tbl[h.idx] + 1;
      else     m_tbl[h.idx] = (m_tbl[h.idx] == 0) ? 0 : m_tbl[h.idx] - 1;
    end
    if (uacc) begin
      m_q.push_back({uidx, ut});
      m_ghr = ((m_ghr << 1) | int'(ut)) & 63;
    end
    if (m_init > 0) m_init--;
    chk("pred_valid", {31'd0, o_pred_valid}, {31'd0, e_pv});
    if (e_pv) begin
      chk("pred_taken", {31'd0, o_pred_taken}, {31'd0, e_pt});
      chk("pred_idx", {26'd0, o_pred_idx}, e_pi);
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) apply(0, 32'd0, 0, 6'd0, 0);
  endtask

  task automatic look(int idx);
    apply(1, 32'(((idx ^ m_ghr) & 63) << 2), 0, 6'd0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_lookup_valid = 0; i_lookup_pc = 0; i_upd_valid = 0; i_upd_idx = 0; i_upd_taken = 0;
    #1;
    chk("rst_pred_valid", {31'd0, o_pred_valid}, 0);
    chk("rst_pred_taken", {31'd0, o_pred_taken}, 0);
    chk("rst_pred_idx", {26'd0, o_pred_idx}, 0);
    chk("rst_init_busy", {31'd0, o_init_busy}, 1);
    chk("rst_lookup_ready", {31'd0, o_lookup_ready}, 0);
    chk("rst_upd_ready", {31'd0, o_upd_ready}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    m_ghr = 0;
    foreach (m_tbl[i]) m_tbl[i] = 0;
    m_init = NENT;
    e_pv = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, nvec %0d", nvec);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    bit rl;

    //      lv  pc      uv idx ut   ev et ei
    vt[0]  = '{1, 32'h100, 0, 6'd0, 0, 1, 0, 6'd0};
    vt[1]  = '{0, 32'h0,   1, 6'd5, 1, 0, 0, 6'd0};
    vt[2]  = '{0, 32'h0,   0, 6'd0, 0, 0, 0, 6'd0};
    vt[3]  = '{1, 32'h10,  0, 6'd0, 0, 1, 0, 6'd5};
    vt[4]  = '{0, 32'h0,   1, 6'd5, 1, 0, 0, 6'd0};
    vt[5]  = '{0, 32'h0,   1, 6'd5, 1, 0, 0, 6'd0};
    vt[6]  = '{0, 32'h0,   0, 6'd0, 0, 0, 0, 6'd0};
    vt[7]  = '{1, 32'h08,  0, 6'd0, 0, 1, 1, 6'd5};
    vt[8]  = '{0, 32'h0,   1, 6'd5, 0, 0, 0, 6'd0};
    vt[9]  = '{1, 32'h2C,  0, 6'd0, 0, 1, 1, 6'd5};
    vt[10] = '{0, 32'h0,   0, 6'd0, 0, 0, 0, 6'd0};
    vt[11] = '{1, 32'h2C,  0, 6'd0, 0, 1, 1, 6'd5};

    do_reset();

    // Init sweep length
    busy_cycles = 0;
    for (int k = 0; k < 70; k++) begin
      if (o_init_busy) busy_cycles++;
      idle(1);
    end
    chk("init_len", busy_cycles, NENT);

    // Training / stale-read vectors from a clean table
    for (int i = 0; i < 12; i++) begin
      apply(vt[i].lv, vt[i].pc, vt[i].uv, vt[i].uidx, vt[i].ut);
      chk("tbl_pred_valid", {31'd0, o_pred_valid}, {31'd0, vt[i].ev});
      if (vt[i].ev) begin
        chk("tbl_pred_taken", {31'd0, o_pred_taken}, {31'd0, vt[i].et});
        chk("tbl_pred_idx", {26'd0, o_pred_idx}, {26'd0, vt[i].ei});
      end
    end

    // Saturation on idx 3
    for (int k = 0; k < 5; k++) apply(0, 0, 1, 6'd3, 1);
    idle(QD + 1);
    look(3); chk("sat_up_taken", {31'd0, o_pred_taken}, 1);
    apply(0, 0, 1, 6'd3, 0); idle(2);
    look(3); chk("sat_one_nt_taken", {31'd0, o_pred_taken}, 1);
    for (int k = 0; k < 5; k++) apply(0, 0, 1, 6'd3, 0);
    idle(QD + 1);
    look(3); chk("sat_down_taken", {31'd0, o_pred_taken}, 0);
    apply(0, 0, 1, 6'd3, 1); idle(2);
    look(3); chk("sat_nowrap_taken", {31'd0, o_pred_taken}, 0);
    apply(0, 0, 1, 6'd3, 1); idle(2);
    look(3); chk("sat_recover_taken", {31'd0, o_pred_taken}, 1);

    // Continuous lookups while the queue fills
    for (int k = 0; k < 8; k++) begin
      rl = o_lookup_ready;
      apply(1, $urandom, 1, 6'($urandom), 1'($urandom));
      if (k == 4) chk("full_lookup_ready", {31'd0, rl}, 0);
      if (k == 5) chk("resume_lookup_ready", {31'd0, rl}, 1);
    end
    idle(QD + 1);

    // Random traffic
    for (int k = 0; k < 400; k++)
      apply(($urandom % 4) != 0, $urandom, 1'($urandom), 6'($urandom), 1'($urandom));
    idle(QD + 1);

    // Mid-run reset with two updates pending and a prediction in flight
    apply(1, 32'h40, 1, 6'd5, 1);
    apply(1, 32'h44, 1, 6'd5, 1);
    chk("pre_rst_pred_valid", {31'd0, o_pred_valid}, 1);
    do_reset();
    busy_cycles = 0;
    for (int k = 0; k < 70; k++) begin
      if (o_init_busy) busy_cycles++;
      idle(1);
    end
    chk("reinit_len", busy_cycles, NENT);

    // GHR indexing after reset: outcomes 1,0,1
    apply(0, 0, 1, 6'd9, 1);
    apply(0, 0, 1, 6'd9, 0);
    apply(0, 0, 1, 6'd9, 1);
    apply(1, 32'h0, 0, 6'd0, 0);
    chk("ghr_idx", {26'd0, o_pred_idx}, 32'h05);
    chk("ghr_trained_cleared", {31'd0, o_pred_taken}, 0);
    idle(QD + 1);
    look(3); chk("idx3_cleared", {31'd0, o_pred_taken}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
